// File: rtl/ahb_master_req.sv
// AHB master request engine: HBUSREQ/HGRANT handshake followed by an INCR burst
// of 1..P_MAX_LEN word beats, with wait states, ERROR responses and grant loss.
module ahb_master_req #(
   parameter int unsigned P_MAX_LEN = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   output logic        HBUSREQ,
   input  logic        HGRANT,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   input  logic [31:0] HRDATA,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] wr_data,
   output logic        wr_pop,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        done,
   output logic        error
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 5;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER,
      ST_LAST
   } state_e;

   state_e          state_q, state_d;
   logic            own_q, own_d;
   logic [LW-1:0]   rem_q, rem_d;
   logic            dph_q, dph_d;
   logic            err_q, err_d;
   logic            hbusreq_q, hbusreq_d;
   logic [1:0]      htrans_q, htrans_d;
   logic [AW-1:0]   haddr_q, haddr_d;
   logic            hwrite_q, hwrite_d;
   logic [DW-1:0]   hwdata_q, hwdata_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            rd_valid_q, rd_valid_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic            accept_c;
   logic            resp_ok_c;
   logic            resp_err_c;
   logic [AW-1:0]   next_addr_c;
   logic [LW-1:0]   len_c;

   assign resp_ok_c   = (HRESP == 2'b00);
   assign next_addr_c = haddr_q + AW'(4);
   // First cycle of a two-cycle ERROR response on one of our data phases
   assign resp_err_c  = dph_q && !HREADY && !resp_ok_c;

   // Command length normalised to 1..P_MAX_LEN
   always_comb begin
      len_c = cmd_len;
      if (cmd_len == LW'(0)) begin
         len_c = LW'(1);
      end else if (cmd_len > LW'(P_MAX_LEN)) begin
         len_c = LW'(P_MAX_LEN);
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         own_q       <= 1'b0;
         rem_q       <= '0;
         dph_q       <= 1'b0;
         err_q       <= 1'b0;
         hbusreq_q   <= 1'b0;
         htrans_q    <= TR_IDLE;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         cmd_ready_q <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         rem_q       <= rem_d;
         dph_q       <= dph_d;
         err_q       <= err_d;
         hbusreq_q   <= hbusreq_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hwdata_q    <= hwdata_d;
         cmd_ready_q <= cmd_ready_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      own_d      = own_q;
      rem_d      = rem_q;
      dph_d      = dph_q;
      err_d      = err_q;
      hbusreq_d  = hbusreq_q;
      htrans_d   = htrans_q;
      haddr_d    = haddr_q;
      hwrite_d   = hwrite_q;
      hwdata_d   = hwdata_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      accept_c   = 1'b0;

      if (HREADY) begin
         own_d = HGRANT;
      end

      // Data phase retires on HREADY; an errored read beat yields no data
      if (dph_q && HREADY) begin
         dph_d = 1'b0;
         if (!hwrite_q && resp_ok_c) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
         end
      end
      if (dph_q && !resp_ok_c) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               haddr_d   = cmd_addr & ~AW'(3);
               rem_d     = len_c;
               hwrite_d  = cmd_write;
               hbusreq_d = 1'b1;
               err_d     = 1'b0;
               state_d   = ST_REQ;
            end
         end

         ST_REQ: begin
            if (resp_err_c) begin
               rem_d     = '0;
               hbusreq_d = 1'b0;
               state_d   = ST_LAST;
            end else if (own_d) begin
               htrans_d  = TR_NONSEQ;
               hbusreq_d = (rem_q != LW'(1));
               state_d   = ST_XFER;
            end
         end

         ST_XFER: begin
            if (resp_err_c) begin
               htrans_d  = TR_IDLE;
               rem_d     = '0;
               hbusreq_d = 1'b0;
               state_d   = ST_LAST;
            end else if (HREADY) begin
               accept_c = 1'b1;
               dph_d    = 1'b1;
               haddr_d  = next_addr_c;
               rem_d    = rem_q - LW'(1);
               if (hwrite_q) begin
                  hwdata_d = wr_data;
               end
               if (rem_q == LW'(1)) begin
                  htrans_d  = TR_IDLE;
                  hbusreq_d = 1'b0;
                  state_d   = ST_LAST;
               end else if (!HGRANT) begin
                  // Grant lost: park at the next address and re-arbitrate
                  htrans_d  = TR_IDLE;
                  hbusreq_d = 1'b1;
                  state_d   = ST_REQ;
               end else begin
                  htrans_d  = (next_addr_c[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                  hbusreq_d = (rem_q != LW'(2));
               end
            end
         end

         ST_LAST: begin
            if (HREADY) begin
               done_d    = 1'b1;
               error_d   = err_q || !resp_ok_c;
               err_d     = 1'b0;
               htrans_d  = TR_IDLE;
               hbusreq_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   assign HBUSREQ   = hbusreq_q;
   assign HTRANS    = htrans_q;
   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b001;
   assign cmd_ready = cmd_ready_q;
   assign wr_pop    = accept_c && hwrite_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_ahb_master_req.sv
// Directed bench for ahb_master_req: a small slave/arbiter model, per-scenario tasks
// with hand-computed expected beats, read data and completion status.
module tb_ahb_master_req;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HBUSREQ;
   logic        HGRANT = 1'b0;
   logic        HREADY = 1'b1;
   logic [1:0]  HRESP = 2'b00;
   logic [31:0] HRDATA;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = 32'h0;
   logic [4:0]  cmd_len = 5'd0;
   logic [31:0] wr_data;
   logic        wr_pop;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   // Monitor state
   logic [31:0] acc_addr [$];
   logic [1:0]  acc_trans [$];
   logic        acc_breq [$];
   logic [31:0] rdq [$];
   logic [31:0] wdq [$];
   int          wr_pops = 0;
   int          done_cnt = 0;
   logic        last_err = 1'b0;

   // Slave data-phase tracking and write-data source
   logic        dph_act;
   logic        dph_wr;
   logic [15:0] dph_addr;
   logic [31:0] wr_idx = 32'd0;

   ahb_master_req #(.P_MAX_LEN(16)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HBUSREQ   (HBUSREQ),
      .HGRANT    (HGRANT),
      .HREADY    (HREADY),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HWDATA    (HWDATA),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_data   (wr_data),
      .wr_pop    (wr_pop),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .done      (done),
      .error     (error)
   );

   always #5 HCLK = ~HCLK;

   assign HRDATA  = {16'hDA7A, dph_addr};
   assign wr_data = 32'hCAFE_0000 + wr_idx;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dph_act  <= 1'b0;
         dph_wr   <= 1'b0;
         dph_addr <= 16'h0;
      end else if (HREADY) begin
         dph_act  <= HTRANS[1];
         dph_wr   <= HWRITE;
         dph_addr <= HADDR[15:0];
      end
   end

   always @(posedge HCLK) begin
      if (wr_pop) wr_idx <= wr_idx + 32'd1;
   end

   always @(negedge HCLK) begin
      if (HRESETn) begin
         if (HTRANS[1] && HREADY) begin
            acc_addr.push_back(HADDR);
            acc_trans.push_back(HTRANS);
            acc_breq.push_back(HBUSREQ);
         end
         if (wr_pop) wr_pops++;
         if (rd_valid) rdq.push_back(rd_data);
         if (dph_act && dph_wr && HREADY) wdq.push_back(HWDATA);
         if (done) begin
            done_cnt++;
            last_err = error;
         end
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [4:0] l);
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      tick();
      tick();
      checks++;
      if ({HBUSREQ, HTRANS, HADDR, HWRITE, HWDATA} !== 68'h0) begin
         errors++;
         $display("FAIL reset_bus got %h want 0", {HBUSREQ, HTRANS, HADDR, HWRITE, HWDATA});
      end
      checks++;
      if ({cmd_ready, wr_pop, rd_valid, rd_data, done, error} !== {1'b1, 36'h0}) begin
         errors++;
         $display("FAIL reset_cmd got %h want %h", {cmd_ready, wr_pop, rd_valid, rd_data, done, error}, {1'b1, 36'h0});
      end
      checks++;
      if (HSIZE !== 3'b010 || HBURST !== 3'b001) begin
         errors++;
         $display("FAIL reset_const got %b/%b want 010/001", HSIZE, HBURST);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || HTRANS !== TR_IDLE) begin
         errors++;
         $display("FAIL reset_release cmd_ready %b htrans %b want 1 00", cmd_ready, HTRANS);
      end
   endtask

   task automatic test_single_write();
      int a0, w0, p0, d0;
      logic [31:0] wbase;
      a0 = acc_addr.size(); w0 = wdq.size(); p0 = wr_pops; d0 = done_cnt;
      wbase = 32'hCAFE_0000 + wr_idx;
      HGRANT = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
      send_cmd(1'b1, 32'h100, 5'd1);
      checks++;
      if (HBUSREQ !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL t1_req busreq %b cmd_ready %b want 1 0", HBUSREQ, cmd_ready);
      end
      tick();
      tick();
      checks++;
      if (HTRANS !== TR_IDLE) begin
         errors++;
         $display("FAIL t1_wait_grant htrans %b want 00", HTRANS);
      end
      HGRANT = 1'b1;
      for (int c = 0; c < 30 && done_cnt == d0; c++) tick();
      checks++;
      if (done_cnt !== d0 + 1 || last_err !== 1'b0) begin
         errors++;
         $display("FAIL t1_done count %0d err %b want %0d 0", done_cnt, last_err, d0 + 1);
      end
      checks++;
      if (acc_addr.size() != a0 + 1 || acc_addr[a0] !== 32'h100 || acc_trans[a0] !== TR_NONSEQ
          || acc_breq[a0] !== 1'b0) begin
         errors++;
         $display("FAIL t1_beat n %0d addr %h trans %b breq %b want 1 00000100 10 0",
                  acc_addr.size() - a0, acc_addr[a0], acc_trans[a0], acc_breq[a0]);
      end
      checks++;
      if (wr_pops !== p0 + 1 || wdq.size() != w0 + 1 || wdq[w0] !== wbase) begin
         errors++;
         $display("FAIL t1_wdata pops %0d hwdata %h want %0d %h", wr_pops - p0, wdq[w0], 1, wbase);
      end
   endtask

   task automatic test_read_stall();
      int a0, r0, d0, stall_left;
      bit stalled;
      logic [1:0] et [0:3];
      logic       eb [0:3];
      a0 = acc_addr.size(); r0 = rdq.size(); d0 = done_cnt;
      stalled = 1'b0; stall_left = 0;
      et = '{TR_NONSEQ, TR_SEQ, TR_SEQ, TR_SEQ};
      eb = '{1'b1, 1'b1, 1'b1, 1'b0};
      HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
      send_cmd(1'b0, 32'h200, 5'd4);
      for (int c = 0; c < 60 && done_cnt == d0; c++) begin
         if (!stalled && acc_addr.size() - a0 == 2) begin
            stalled = 1'b1;
            stall_left = 2;
         end
         if (stall_left > 0) begin
            HREADY = 1'b0;
            checks++;
            if (HADDR !== 32'h208 || HTRANS !== TR_SEQ) begin
               errors++;
               $display("FAIL t2_stall_hold addr %h trans %b want 00000208 11", HADDR, HTRANS);
            end
            stall_left--;
         end else begin
            HREADY = 1'b1;
         end
         tick();
      end
      HREADY = 1'b1;
      checks++;
      if (done_cnt !== d0 + 1 || last_err !== 1'b0) begin
         errors++;
         $display("FAIL t2_done count %0d err %b want %0d 0", done_cnt, last_err, d0 + 1);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc_addr.size() <= a0 + i || acc_addr[a0+i] !== 32'h200 + 32'(4 * i)
             || acc_trans[a0+i] !== et[i] || acc_breq[a0+i] !== eb[i]) begin
            errors++;
            $display("FAIL t2_beat%0d addr %h trans %b breq %b want %h %b %b", i, acc_addr[a0+i],
                     acc_trans[a0+i], acc_breq[a0+i], 32'h200 + 32'(4 * i), et[i], eb[i]);
         end
      end
      checks++;
      if (rdq.size() != r0 + 4) begin
         errors++;
         $display("FAIL t2_rd_count got %0d want 4", rdq.size() - r0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdq.size() <= r0 + i || rdq[r0+i] !== 32'hDA7A_0200 + 32'(4 * i)) begin
            errors++;
            $display("FAIL t2_rd%0d got %h want %h", i, rdq[r0+i], 32'hDA7A_0200 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_boundary_write();
      int a0, w0, p0, d0;
      logic [31:0] wbase;
      logic [31:0] ea [0:3];
      logic [1:0]  et [0:3];
      a0 = acc_addr.size(); w0 = wdq.size(); p0 = wr_pops; d0 = done_cnt;
      wbase = 32'hCAFE_0000 + wr_idx;
      ea = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
      et = '{TR_NONSEQ, TR_SEQ, TR_NONSEQ, TR_SEQ};
      HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
      send_cmd(1'b1, 32'h3F8, 5'd4);
      for (int c = 0; c < 40 && done_cnt == d0; c++) tick();
      checks++;
      if (done_cnt !== d0 + 1 || last_err !== 1'b0) begin
         errors++;
         $display("FAIL t3_done count %0d err %b want %0d 0", done_cnt, last_err, d0 + 1);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc_addr.size() <= a0 + i || acc_addr[a0+i] !== ea[i] || acc_trans[a0+i] !== et[i]) begin
            errors++;
            $display("FAIL t3_beat%0d addr %h trans %b want %h %b", i, acc_addr[a0+i],
                     acc_trans[a0+i], ea[i], et[i]);
         end
      end
      checks++;
      if (wr_pops !== p0 + 4) begin
         errors++;
         $display("FAIL t3_pops got %0d want 4", wr_pops - p0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wdq.size() <= w0 + i || wdq[w0+i] !== wbase + 32'(i)) begin
            errors++;
            $display("FAIL t3_hwdata%0d got %h want %h", i, wdq[w0+i], wbase + 32'(i));
         end
      end
   endtask

   task automatic test_grant_loss();
      int a0, r0, d0, gap;
      bit dropped;
      a0 = acc_addr.size(); r0 = rdq.size(); d0 = done_cnt;
      dropped = 1'b0; gap = 0;
      HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
      send_cmd(1'b0, 32'h500, 5'd8);
      for (int c = 0; c < 120 && done_cnt == d0; c++) begin
         if (!dropped && HTRANS[1] && acc_addr.size() - a0 == 2) begin
            HGRANT = 1'b0;
            dropped = 1'b1;
         end else if (dropped && gap < 5) begin
            checks++;
            if (HTRANS !== TR_IDLE || HBUSREQ !== 1'b1) begin
               errors++;
               $display("FAIL t4_gap%0d htrans %b busreq %b want 00 1", gap, HTRANS, HBUSREQ);
            end
            gap++;
            if (gap == 5) HGRANT = 1'b1;
         end
         tick();
      end
      HGRANT = 1'b1;
      checks++;
      if (done_cnt !== d0 + 1 || last_err !== 1'b0) begin
         errors++;
         $display("FAIL t4_done count %0d err %b want %0d 0", done_cnt, last_err, d0 + 1);
      end
      checks++;
      if (acc_addr.size() != a0 + 8) begin
         errors++;
         $display("FAIL t4_beat_count got %0d want 8", acc_addr.size() - a0);
      end
      for (int i = 0; i < 8; i++) begin
         logic [1:0] t_exp;
         t_exp = (i == 0 || i == 3) ? TR_NONSEQ : TR_SEQ;
         checks++;
         if (acc_addr.size() <= a0 + i || acc_addr[a0+i] !== 32'h500 + 32'(4 * i)
             || acc_trans[a0+i] !== t_exp || acc_breq[a0+i] !== (i != 7)) begin
            errors++;
            $display("FAIL t4_beat%0d addr %h trans %b breq %b want %h %b %b", i, acc_addr[a0+i],
                     acc_trans[a0+i], acc_breq[a0+i], 32'h500 + 32'(4 * i), t_exp, (i != 7));
         end
      end
      checks++;
      if (rdq.size() != r0 + 8) begin
         errors++;
         $display("FAIL t4_rd_count got %0d want 8", rdq.size() - r0);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rdq.size() <= r0 + i || rdq[r0+i] !== 32'hDA7A_0500 + 32'(4 * i)) begin
            errors++;
            $display("FAIL t4_rd%0d got %h want %h", i, rdq[r0+i], 32'hDA7A_0500 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_error();
      int a0, p0, d0, phase;
      a0 = acc_addr.size(); p0 = wr_pops; d0 = done_cnt; phase = 0;
      HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
      send_cmd(1'b1, 32'h600, 5'd4);
      for (int c = 0; c < 40 && done_cnt == d0; c++) begin
         if (phase == 0 && acc_addr.size() - a0 == 2) begin
            HREADY = 1'b0;
            HRESP  = 2'b01;
            phase  = 1;
         end else if (phase == 1) begin
            checks++;
            if (HTRANS !== TR_IDLE || HBUSREQ !== 1'b0) begin
               errors++;
               $display("FAIL t5_cancel htrans %b busreq %b want 00 0", HTRANS, HBUSREQ);
            end
            HREADY = 1'b1;
            HRESP  = 2'b01;
            phase  = 2;
         end else begin
            HREADY = 1'b1;
            HRESP  = 2'b00;
         end
         tick();
      end
      HREADY = 1'b1;
      HRESP  = 2'b00;
      tick();
      tick();
      checks++;
      if (done_cnt !== d0 + 1 || last_err !== 1'b1) begin
         errors++;
         $display("FAIL t5_done count %0d err %b want %0d 1", done_cnt, last_err, d0 + 1);
      end
      checks++;
      if (acc_addr.size() != a0 + 2) begin
         errors++;
         $display("FAIL t5_beats got %0d want 2", acc_addr.size() - a0);
      end
      checks++;
      if (wr_pops !== p0 + 2) begin
         errors++;
         $display("FAIL t5_pops got %0d want 2", wr_pops - p0);
      end
   endtask

   task automatic test_reset_mid_burst();
      int a0, d0;
      a0 = acc_addr.size(); d0 = done_cnt;
      HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
      send_cmd(1'b0, 32'h700, 5'd8);
      for (int c = 0; c < 40 && acc_addr.size() - a0 < 3; c++) tick();
      #2;
      HRESETn = 1'b0;
      #1;
      checks++;
      if ({HBUSREQ, HTRANS, HADDR, HWRITE, HWDATA} !== 68'h0) begin
         errors++;
         $display("FAIL t6_bus got %h want 0", {HBUSREQ, HTRANS, HADDR, HWRITE, HWDATA});
      end
      checks++;
      if ({cmd_ready, wr_pop, rd_valid, rd_data, done, error} !== {1'b1, 36'h0}) begin
         errors++;
         $display("FAIL t6_cmd got %h want %h", {cmd_ready, wr_pop, rd_valid, rd_data, done, error}, {1'b1, 36'h0});
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      checks++;
      if (done_cnt !== d0 || cmd_ready !== 1'b1 || HBUSREQ !== 1'b0) begin
         errors++;
         $display("FAIL t6_after done %0d cmd_ready %b busreq %b want 0 1 0", done_cnt - d0, cmd_ready, HBUSREQ);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_read_stall();
      test_boundary_write();
      test_grant_loss();
      test_error();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_master_req.md
Name: ahb_master_req

Overview:
- Simple single-port AHB master engine. It is the requesting end of the HBUSREQ/HGRANT handshake served by the team's 2-master AHB arbiter.
- Accepts one command at a time: read or write, word size, 1..P_MAX_LEN beats.
- Flow: raises HBUSREQ, waits for grant, then issues an INCR burst.
- Handles wait states, ERROR responses and grant loss mid-burst. One instance per master port.

Parameters:
- P_MAX_LEN, 16, maximum beats per command; cmd_len width is 5.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HBUSREQ  out  1  bus request to arbiter.
- HGRANT  in  1  grant from arbiter.
- HREADY  in  1  bus ready.
- HRESP  in  2  response: 00 OKAY, 01 ERROR; others treated as ERROR.
- HRDATA  in  32  read data.
- HADDR  out  32  address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ, 11 SEQ.
- HWRITE  out  1  write when 1.
- HSIZE  out  3  fixed 3'b010.
- HBURST  out  3  fixed 3'b001 (INCR).
- HWDATA  out  32  write data.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle, command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1 = write.
- cmd_addr  in  32  start address; bits [1:0] forced to 0.
- cmd_len  in  5  beats, 1..P_MAX_LEN; 0 is treated as 1.
- wr_data  in  32  next write beat; source must always hold valid data during a write command.
- wr_pop  out  1  1-cycle strobe, wr_data consumed.
- rd_valid  out  1  1-cycle strobe, rd_data valid.
- rd_data  out  32  read beat.
- done  out  1  1-cycle strobe, command finished.
- error  out  1  qualifies done; 1 if any beat got ERROR.

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous and active-low.
- Reset values:
  - HBUSREQ=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0.
  - cmd_ready=1, wr_pop=0, rd_valid=0, rd_data=0, done=0, error=0.
  - HSIZE/HBURST are constants.
  - Reset mid-burst aborts immediately with no done.
- Ownership: own <= HGRANT, updated only at edges with HREADY=1. The address bus is driven with non-IDLE HTRANS only while own=1.
- States:
  - IDLE: cmd_ready=1. On accept, latch addr/len/write, set HBUSREQ=1, go to REQ.
  - REQ: HTRANS=IDLE. When own=1, go to XFER with HTRANS=NONSEQ at the current address.
  - XFER: an address beat is accepted at an edge with HREADY=1.
    - On accept: addr+=4, remaining-=1.
    - Next beat is SEQ, or NONSEQ if the new addr[9:0]==0 (1KB boundary).
    - HBUSREQ drops in the cycle the last address beat is driven.
    - After the last accept, HTRANS=IDLE; go to LAST.
  - LAST: wait for the final data phase (HREADY=1), then pulse done for 1 cycle and return to IDLE.
- Data phase:
  - Write: at the edge accepting address beat i, HWDATA<=wr_data and wr_pop=1 in that cycle (combinational on accept).
  - Read: at an edge with HREADY=1 during a read data phase, rd_data<=HRDATA and rd_valid=1 next cycle.
  - Data phases of beats i and i+1 overlap address phases by one cycle (standard pipeline). Latency from cmd accept to first NONSEQ is ≥2 cycles.
- Grant loss: own falls at an edge (HREADY=1) with beats remaining.
  - Complete the outstanding data phase.
  - Drive HTRANS=IDLE and keep HBUSREQ=1.
  - Go to REQ; on regrant, resume with NONSEQ at the saved next address.
  - No beat is duplicated or skipped.
- ERROR: on HRESP=ERROR with HREADY=0 (first cycle of the 2-cycle response), drive HTRANS=IDLE next cycle and cancel remaining beats. Drop HBUSREQ, set error, and pulse done after HREADY=1. For a read, the errored beat produces no rd_valid.
- HWRITE and HADDR hold their values while HREADY=0.
- New commands are not accepted until done has pulsed.

Test Plan:
1. Single write, cmd_addr=0x100, len=1, HGRANT=1 two cycles after HBUSREQ, HREADY=1.
   -> One NONSEQ at 0x100, HWDATA=wr_data, wr_pop once, done=1, error=0.
2. Read len=4 at 0x200, HREADY=0 for 2 cycles on beat 2.
   -> HADDR 0x200 NONSEQ, then 0x204/0x208/0x20C SEQ; address held during the stall; 4 rd_valid pulses in order; HBUSREQ low while 0x20C is driven.
3. Write len=4 at 0x3F8.
   -> Beats 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
4. Read len=8, HGRANT deasserted after 3rd address accepted, regranted 5 cycles later.
   -> IDLE during the gap, HBUSREQ stays 1, resume NONSEQ at start+12, exactly 8 rd_valid.
5. Write len=4, HRESP=ERROR on beat 2 data phase.
   -> HTRANS=IDLE next cycle, no further address beats, done=1 with error=1, wr_pop count=2.
6. Assert HRESETn=0 mid-burst.
   -> All outputs return to reset values immediately; after release cmd_ready=1 and no done.
